// File: rtl/clint_if.sv
// Data memory bus between the core and the core-local interruptor.
// The initiator holds mem_valid until the one-cycle mem_ready pulse.
interface clint_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/clint.sv
// Core-local interruptor: msip register, prescaled 64-bit mtime, mtimecmp and registered mtip,
// served as a single-outstanding responder on the data memory bus.
module clint #(
    parameter int unsigned RTC_DIV = 1  // clock cycles per mtime increment, 1..65535
) (
    input  logic        clk,
    input  logic        rst,
    clint_if.slave      bus,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime
);

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } state_e;

    // Word offsets, mem_addr[15:2]
    localparam logic [13:0] OffMsip   = 14'h0000;
    localparam logic [13:0] OffCmpLo  = 14'h1000;
    localparam logic [13:0] OffCmpHi  = 14'h1001;
    localparam logic [13:0] OffTimeLo = 14'h2FFE;
    localparam logic [13:0] OffTimeHi = 14'h2FFF;

    localparam logic [15:0] PreMax = 16'(RTC_DIV - 1);

    state_e      state_q;
    logic [15:0] pre_q;
    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtime_inc;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        msip_q;
    logic        msip_d;
    logic        mtip_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        tick;
    logic        req;
    logic        wr;
    logic [13:0] word;
    logic [31:0] rd_word;
    logic        unused_bus;

    // Fetch flag and undecoded address bits are intentionally ignored.
    assign unused_bus = ^{bus.mem_instr, bus.mem_addr[31:16], bus.mem_addr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : old[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        tick      = (pre_q == PreMax);
        mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;
        word      = bus.mem_addr[15:2];
        req       = (state_q == StIdle) && bus.mem_valid;
        wr        = req && (bus.mem_wstrb != 4'b0000);

        case (word)
            OffMsip:   rd_word = {31'b0, msip_q};
            OffCmpLo:  rd_word = mtimecmp_q[31:0];
            OffCmpHi:  rd_word = mtimecmp_q[63:32];
            OffTimeLo: rd_word = mtime_q[31:0];
            OffTimeHi: rd_word = mtime_q[63:32];
            default:   rd_word = '0;
        endcase

        // A software write to mtime lands on top of this cycle's increment, per byte lane.
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_inc;
        if (wr) begin
            case (word)
                OffMsip: begin
                    if (bus.mem_wstrb[0]) begin
                        msip_d = bus.mem_wdata[0];
                    end
                end
                OffCmpLo: begin
                    mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus.mem_wdata, bus.mem_wstrb);
                end
                OffCmpHi: begin
                    mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.mem_wdata,
                                                    bus.mem_wstrb);
                end
                OffTimeLo: begin
                    mtime_d[31:0] = merge_bytes(mtime_inc[31:0], bus.mem_wdata, bus.mem_wstrb);
                end
                OffTimeHi: begin
                    mtime_d[63:32] = merge_bytes(mtime_inc[63:32], bus.mem_wdata, bus.mem_wstrb);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            pre_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            pre_q      <= tick ? 16'd0 : pre_q + 16'd1;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= (mtime_q >= mtimecmp_q);

            case (state_q)
                StIdle: begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                    if (req) begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                        rdata_q <= wr ? 32'd0 : rd_word;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign msip          = msip_q;
    assign mtip          = mtip_q;
    assign mtime         = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: one instance with RTC_DIV=1 for bus/timer features, one with RTC_DIV=4
// for the prescaler; expected values come from a cycle-count model of mtime.
module tb_clint;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clint_if bus0 ();
    clint_if bus4 ();

    logic        msip0;
    logic        mtip0;
    logic [63:0] mtime0;
    logic        msip4;
    logic        mtip4;
    logic [63:0] mtime4;

    clint #(.RTC_DIV(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0),
        .msip (msip0),
        .mtip (mtip0),
        .mtime(mtime0)
    );

    clint #(.RTC_DIV(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus4),
        .msip (msip4),
        .mtip (mtip4),
        .mtime(mtime4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // mtime after edge c = last written value + ticks since then; ticks land on every
    // div-th edge counted from the last reset edge.
    int          div_m   [2] = '{1, 4};
    logic [63:0] mt_val  [2];
    int          mt_cyc  [2];
    int          pre_cyc [2];
    logic [63:0] cmp_m   [2];
    logic        msip_m  [2];

    function automatic int ticks(input int d, input int a, input int b);
        return (b - pre_cyc[d]) / div_m[d] - (a - pre_cyc[d]) / div_m[d];
    endfunction

    function automatic logic [63:0] mtime_at(input int d, input int c);
        return mt_val[d] + 64'(ticks(d, mt_cyc[d], c));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            mt_val[d]  = '0;
            mt_cyc[d]  = cyc;
            pre_cyc[d] = cyc;
            cmp_m[d]   = '1;
            msip_m[d]  = 1'b0;
        end
    endfunction

    int          b_lat;
    int          b_acc;
    logic [31:0] b_rdata;
    logic        b_rdy_next;
    logic        ack_msip;
    logic        ack_mtip;
    logic [63:0] ack_mtime;

    task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] s);
        if (d == 0) begin
            bus0.mem_valid = v; bus0.mem_instr = 1'($urandom); bus0.mem_addr = a;
            bus0.mem_wdata = w; bus0.mem_wstrb = s;
        end else begin
            bus4.mem_valid = v; bus4.mem_instr = 1'($urandom); bus4.mem_addr = a;
            bus4.mem_wdata = w; bus4.mem_wstrb = s;
        end
    endtask

    // One access; returns one cycle after the ready pulse, model updated at the accept edge.
    task automatic access(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
        logic        rdy;
        logic [13:0] off;
        logic [63:0] t;
        @(negedge clk);
        drive(d, 1'b1, addr, wdata, strb);
        b_lat = 0;
        rdy   = 1'b0;
        while (!rdy && b_lat < 8) begin
            @(posedge clk);
            #1;
            b_lat++;
            rdy = (d == 0) ? bus0.mem_ready : bus4.mem_ready;
        end
        b_acc     = cyc;
        b_rdata   = (d == 0) ? bus0.mem_rdata : bus4.mem_rdata;
        ack_msip  = (d == 0) ? msip0 : msip4;
        ack_mtip  = (d == 0) ? mtip0 : mtip4;
        ack_mtime = (d == 0) ? mtime0 : mtime4;
        drive(d, 1'b0, 32'h0, 32'h0, 4'h0);
        if (strb != 4'h0) begin
            off = addr[15:2];
            if (off == 14'h0000) begin
                if (strb[0]) msip_m[d] = wdata[0];
            end else if (off == 14'h1000) begin
                cmp_m[d][31:0] = merge(cmp_m[d][31:0], wdata, strb);
            end else if (off == 14'h1001) begin
                cmp_m[d][63:32] = merge(cmp_m[d][63:32], wdata, strb);
            end else if (off == 14'h2FFE || off == 14'h2FFF) begin
                t = mtime_at(d, b_acc);
                if (off == 14'h2FFE) t[31:0] = merge(t[31:0], wdata, strb);
                else t[63:32] = merge(t[63:32], wdata, strb);
                mt_val[d] = t;
                mt_cyc[d] = b_acc;
            end
        end
        @(posedge clk);
        #1;
        b_rdy_next = (d == 0) ? bus0.mem_ready : bus4.mem_ready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        do_reset();
        checks++; if (bus0.mem_ready !== 1'b0) begin failures++;
            $display("FAIL reset_ready got=%b exp=0", bus0.mem_ready); end
        checks++; if (bus0.mem_rdata !== 32'h0) begin failures++;
            $display("FAIL reset_rdata got=%h exp=0", bus0.mem_rdata); end
        checks++; if (msip0 !== 1'b0 || mtip0 !== 1'b0) begin failures++;
            $display("FAIL reset_irq got=%b%b exp=00", msip0, mtip0); end
        checks++; if (mtime0 !== 64'h0 || mtime4 !== 64'h0) begin failures++;
            $display("FAIL reset_mtime got=%h/%h exp=0", mtime0, mtime4); end
        access(0, 32'h0000_4004, 32'h0, 4'h0);
        checks++; if (b_lat !== 1 || b_rdy_next !== 1'b0) begin failures++;
            $display("FAIL reset_read_lat got=%0d/%b exp=1/0", b_lat, b_rdy_next); end
        checks++; if (b_rdata !== 32'hFFFF_FFFF) begin failures++;
            $display("FAIL reset_cmp_hi got=%h exp=ffffffff", b_rdata); end
        // Reset lands on the edge that would accept an msip write.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 32'h0, 32'h1, 4'hF);
        @(posedge clk);
        #1;
        checks++; if (bus0.mem_ready !== 1'b0) begin failures++;
            $display("FAIL abort_ready got=%b exp=0", bus0.mem_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (bus0.mem_ready !== 1'b0 || msip0 !== 1'b0) begin failures++;
            $display("FAIL abort_after got=%b/%b exp=0/0", bus0.mem_ready, msip0); end
        checks++; if (mtime0 !== mtime_at(0, cyc)) begin failures++;
            $display("FAIL abort_mtime got=%h exp=%h", mtime0, mtime_at(0, cyc)); end
    endtask

    task automatic test_msip();
        logic [31:0] data;
        logic [3:0]  strb;
        access(0, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF);
        checks++; if (ack_msip !== 1'b1 || b_lat !== 1) begin failures++;
            $display("FAIL msip_set got=%b lat=%0d exp=1 lat=1", ack_msip, b_lat); end
        access(0, 32'h0000_0000, 32'h0, 4'h0);
        checks++; if (b_rdata !== 32'h0000_0001) begin failures++;
            $display("FAIL msip_read got=%h exp=00000001", b_rdata); end
        access(0, 32'h0000_0000, 32'h0, 4'hE);
        checks++; if (ack_msip !== 1'b1 || msip0 !== 1'b1) begin failures++;
            $display("FAIL msip_lane got=%b/%b exp=1/1", ack_msip, msip0); end
        for (int i = 0; i < 6; i++) begin
            data = $urandom;
            strb = 4'($urandom);
            access(0, {16'($urandom), 16'h0000}, data, strb);
            checks++; if (ack_msip !== msip_m[0]) begin failures++;
                $display("FAIL msip_rand got=%b exp=%b", ack_msip, msip_m[0]); end
            access(0, 32'h0000_0000, 32'h0, 4'h0);
            checks++; if (b_rdata !== {31'b0, msip_m[0]}) begin failures++;
                $display("FAIL msip_rand_read got=%h exp=%h", b_rdata, {31'b0, msip_m[0]}); end
        end
    endtask

    task automatic test_timer();
        int          c40;
        logic        exp;
        logic [63:0] tnow;
        logic [31:0] tgt;
        access(0, 32'h0000_BFF8, 32'h0000_0030, 4'hF);
        access(0, 32'h0000_4004, 32'h0, 4'hF);
        access(0, 32'h0000_4000, 32'h0000_0040, 4'hF);
        c40 = mt_cyc[0] + int'(32'h40 - mt_val[0][31:0]);
        while (cyc < c40 + 3) begin
            @(posedge clk);
            #1;
            exp = (mtime_at(0, cyc - 1) >= cmp_m[0]);
            checks++; if (mtip0 !== exp) begin failures++;
                $display("FAIL mtip_rise cyc=%0d got=%b exp=%b", cyc - c40, mtip0, exp); end
        end
        access(0, 32'h0000_4004, 32'h0000_0001, 4'hF);
        checks++; if (ack_mtip !== 1'b1 || mtip0 !== 1'b0) begin failures++;
            $display("FAIL mtip_fall got=%b,%b exp=1,0", ack_mtip, mtip0); end
        for (int r = 0; r < 4; r++) begin
            access(0, 32'h0000_4004, 32'hFFFF_FFFF, 4'hF);
            tnow = mtime_at(0, cyc);
            tgt  = tnow[31:0] + 32'($urandom_range(4, 24));
            access(0, 32'h0000_4000, tgt, 4'hF);
            access(0, 32'h0000_4004, 32'h0, 4'hF);
            repeat (30) begin
                @(posedge clk);
                #1;
                exp = (mtime_at(0, cyc - 1) >= cmp_m[0]);
                checks++; if (mtip0 !== exp || mtime0 !== mtime_at(0, cyc)) begin failures++;
                    $display("FAIL timer_rand got=%b/%h exp=%b/%h", mtip0, mtime0, exp,
                             mtime_at(0, cyc)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        er;
        logic [63:0] t;
        logic [31:0] ed;
        @(negedge clk);
        drive(0, 1'b1, 32'hA5A5_BFF8, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            er = (i % 2 == 0);
            t  = mtime_at(0, cyc - 1);
            ed = er ? t[31:0] : 32'h0;
            checks++; if (bus0.mem_ready !== er || bus0.mem_rdata !== ed) begin failures++;
                $display("FAIL b2b_%0d got=%b/%h exp=%b/%h", i, bus0.mem_ready, bus0.mem_rdata,
                         er, ed); end
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_unmapped();
        logic [13:0] off;
        access(0, 32'h0000_2000, 32'h1234_5678, 4'hF);
        checks++; if (b_lat !== 1 || b_rdy_next !== 1'b0) begin failures++;
            $display("FAIL unmap_wr_lat got=%0d/%b exp=1/0", b_lat, b_rdy_next); end
        checks++; if (msip0 !== msip_m[0] || mtime0 !== mtime_at(0, cyc)) begin failures++;
            $display("FAIL unmap_side got=%b/%h exp=%b/%h", msip0, mtime0, msip_m[0],
                     mtime_at(0, cyc)); end
        access(0, 32'h0000_2000, 32'h0, 4'h0);
        checks++; if (b_lat !== 1 || b_rdy_next !== 1'b0 || b_rdata !== 32'h0) begin failures++;
            $display("FAIL unmap_rd got=%0d/%b/%h exp=1/0/0", b_lat, b_rdy_next, b_rdata); end
        for (int i = 0; i < 5; i++) begin
            off = 14'($urandom);
            while (off == 14'h0000 || off == 14'h1000 || off == 14'h1001 || off == 14'h2FFE ||
                   off == 14'h2FFF) off = 14'($urandom);
            access(0, {16'($urandom), off, 2'($urandom)}, $urandom, 4'hF);
            access(0, {16'($urandom), off, 2'b00}, 32'h0, 4'h0);
            checks++; if (b_rdata !== 32'h0) begin failures++;
                $display("FAIL unmap_rand off=%h got=%h exp=0", off, b_rdata); end
        end
        access(0, 32'h0000_4000, 32'h0, 4'h0);
        checks++; if (b_rdata !== cmp_m[0][31:0]) begin failures++;
            $display("FAIL unmap_cmp_lo got=%h exp=%h", b_rdata, cmp_m[0][31:0]); end
        access(0, 32'h0000_4004, 32'h0, 4'h0);
        checks++; if (b_rdata !== cmp_m[0][63:32]) begin failures++;
            $display("FAIL unmap_cmp_hi got=%h exp=%h", b_rdata, cmp_m[0][63:32]); end
    endtask

    task automatic test_wrap_collision();
        logic [31:0] addr;
        logic [63:0] t;
        access(0, 32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF);
        access(0, 32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF);
        checks++; if (ack_mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++;
            $display("FAIL wrap_set got=%h exp=ffffffffffffffff", ack_mtime); end
        checks++; if (mtime0 !== 64'h0) begin failures++;
            $display("FAIL wrap_zero got=%h exp=0", mtime0); end
        access(0, 32'h0000_BFF8, 32'h1234_56FE, 4'hF);
        access(0, 32'h0000_BFF8, 32'h0000_00AB, 4'h1);
        checks++; if (ack_mtime[31:0] !== 32'h1234_57AB) begin failures++;
            $display("FAIL collide_byte0 got=%h exp=123457ab", ack_mtime[31:0]); end
        for (int i = 0; i < 6; i++) begin
            addr = ($urandom % 2 == 0) ? 32'h0000_BFF8 : 32'h0000_BFFC;
            access(0, addr, $urandom, 4'($urandom_range(1, 15)));
            t = mtime_at(0, b_acc);
            checks++; if (ack_mtime !== t) begin failures++;
                $display("FAIL collide_rand got=%h exp=%h", ack_mtime, t); end
            access(0, addr, 32'h0, 4'h0);
            t = mtime_at(0, b_acc - 1);
            checks++; if (b_rdata !== (addr[2] ? t[63:32] : t[31:0])) begin failures++;
                $display("FAIL mtime_read got=%h exp=%h", b_rdata,
                         addr[2] ? t[63:32] : t[31:0]); end
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            checks++; if (mtime4 !== mtime_at(1, cyc)) begin failures++;
                $display("FAIL presc_run k=%0d got=%h exp=%h", k, mtime4, mtime_at(1, cyc)); end
        end
        checks++; if (mtime4 !== 64'd10) begin failures++;
            $display("FAIL presc_40 got=%0d exp=10", mtime4); end
        access(1, 32'h0000_BFF8, $urandom, 4'($urandom_range(1, 15)));
        checks++; if (ack_mtime !== mtime_at(1, b_acc)) begin failures++;
            $display("FAIL presc_wr got=%h exp=%h", ack_mtime, mtime_at(1, b_acc)); end
        repeat (20) begin
            @(posedge clk);
            #1;
            checks++; if (mtime4 !== mtime_at(1, cyc)) begin failures++;
                $display("FAIL presc_after_wr got=%h exp=%h", mtime4, mtime_at(1, cyc)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_msip();
        test_timer();
        test_back_to_back();
        test_unmapped();
        test_wrap_collision();
        test_prescaler();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor: the memory-mapped source of the machine software, timer and time signals that feed the CSR block's `msip`, `mtip` and `mtime` inputs. It sits on the core's data memory bus as a single-outstanding responder. It owns the 64-bit `mtime` counter, advanced by a programmable prescaler, plus the 64-bit `mtimecmp` and 1-bit `msip` registers. It drives `mtip` when `mtime >= mtimecmp`.

## Interface
- `RTC_DIV`, default 1: clock cycles per `mtime` increment; legal range 1..65535.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `mem_valid` input 1: request valid; held by the initiator until `mem_ready`.
- `mem_instr` input 1: instruction-fetch flag; ignored, the access is served as data.
- `mem_addr` input 32: byte address; only `mem_addr[15:2]` is decoded, and the interconnect decodes the base.
- `mem_wdata` input 32: write data.
- `mem_wstrb` input 4: byte write strobes; `0000` means a read.
- `mem_rdata` output 32: read data; valid only while `mem_ready` = 1, else 0.
- `mem_ready` output 1: one-cycle response pulse.
- `msip` output 1: machine software interrupt pending.
- `mtip` output 1: machine timer interrupt pending.
- `mtime` output 64: current time value.

## Operation
- Register map, offsets from `mem_addr[15:0]`:
  - 0x0000: `msip`; only bit0 is implemented, other bits read 0.
  - 0x4000: `mtimecmp[31:0]`.
  - 0x4004: `mtimecmp[63:32]`.
  - 0xBFF8: `mtime[31:0]`.
  - 0xBFFC: `mtime[63:32]`.
- Unmapped offsets:
  - Reads return 0.
  - Writes are ignored.
  - A response is still given.
- Writes apply per byte lane where `mem_wstrb[i]` = 1. For `msip`, only `mem_wstrb[0]` matters.
- The two 32-bit halves are independent:
  - A write to one half never carries into the other.
  - Software uses the usual hi/lo/hi sequencing.
- Responder FSM has two states, IDLE and RESP:
  - IDLE: when `mem_valid` = 1, do the register write or capture the read data into `mem_rdata` at this edge, then go to RESP.
  - RESP: `mem_ready` = 1 for exactly this cycle, and `mem_valid` is ignored. Return to IDLE.
  - If `mem_valid` is still 1 on return to IDLE, it is a new request.
- Prescaler:
  - Counter `pre` is 16 bits and counts 0..RTC_DIV-1.
  - A tick occurs in the cycle `pre` == RTC_DIV-1; `pre` wraps to 0 and `mtime` increments by 1.
  - With RTC_DIV=1, every cycle is a tick.
- `mtime` wraps from 0xFFFFFFFF_FFFFFFFF to 0.
- Simultaneous software write to an `mtime` half and a tick:
  - Lanes written take the written value.
  - Unwritten lanes take the value as it would be after the increment (increment first, then byte merge).
  - `pre` continues unaffected.
- A write to `mtime` or `mtimecmp` never resets `pre`.
- `mtip` is registered:
  - `mtip` <= (`mtime` >= `mtimecmp`), unsigned 64-bit compare on current register values.
  - It clears only through the compare: raise `mtimecmp` or lower `mtime`. It is not writable.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `msip`=0, `mtip`=0.
  - `mtime`=0, `mtimecmp`=0xFFFFFFFF_FFFFFFFF, `pre`=0, FSM=IDLE.
- Reset mid-transaction: FSM returns to IDLE, and no `mem_ready` pulse is emitted for the aborted request.
- Access latency: request seen in cycle N gives `mem_ready`=1 in cycle N+1. Throughput is one access per 2 cycles.
- Register write issued in cycle N:
  - The new value is visible on `msip`/`mtime` in cycle N+1.
  - It is visible in `mtip` in cycle N+2.
- A read returns the value held at the end of cycle N (before that edge's update).
- Tick in cycle T: `mtime` changes at T+1, and `mtip` reflects it at T+2.

## Test plan
- Reset: assert `rst` for 2 cycles, then release.
  - Required: all outputs at their reset values.
  - Read 0x4004 returns 0xFFFFFFFF with `mem_ready` exactly 1 cycle after `mem_valid`.
- msip: write 0xFFFFFFFF, wstrb=1111, to 0x0000.
  - Required: `msip`=1 the next cycle; read of 0x0000 returns 0x00000001.
  - Then write 0 with wstrb=1110. Required: `msip` stays 1.
- Timer:
  - RTC_DIV=1: write `mtimecmp`=0x00000000_00000040 while `mtime`=0x30. Required: `mtip` rises exactly 2 cycles after `mtime` becomes 0x40.
  - Then write `mtimecmp` high word = 1. Required: `mtip` falls 2 cycles after that write's accept.
- Prescaler: RTC_DIV=4, free-run 40 cycles after reset. Required: `mtime`=10, incrementing every 4th cycle.
- Collision and wrap:
  - Write 0xFFFFFFFF to 0xBFF8 and 0xBFFC (high half first).
  - Required: on the next tick `mtime` = 0.
  - Also, a write to 0xBFF8 with wstrb=0001 coinciding with a tick updates byte0 to the written value while bytes 1-3 reflect the increment.
- Unmapped: write 0x12345678 to 0x2000, then read it back. Required: read returns 0, both accesses get a 1-cycle `mem_ready`, and no register changes.
